// File: rtl/bus_master_port_pkg.sv
// Constants shared by the serial bus master and the memory slave: FSM encoding,
// slave-ID field placement and default bus widths.
package bus_master_port_pkg;

    localparam int BUS_ADDRESS_WIDTH = 15;
    localparam int BUS_DATA_WIDTH    = 8;
    localparam int SLAVE_ID_WIDTH    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA,
        ST_DONE
    } bus_state_e;

    // Lowest bit of the slave-ID field; the ID occupies the top SLAVE_ID_WIDTH bits.
    function automatic int slave_id_lsb(input int addr_width);
        return addr_width - SLAVE_ID_WIDTH;
    endfunction

endpackage

// File: rtl/serial_shift_unit.sv
// Loadable PISO/SIPO shift register with a bit counter and last-bit flag.
// Serial data leaves at bit 0; serial data enters at bit last_idx.
module serial_shift_unit #(
    parameter int W  = 15,
    parameter int OW = 8,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          shift_en,
    input  logic          serial_in,
    input  logic [CW-1:0] last_idx,
    output logic          serial_out,
    output logic [OW-1:0] data_nxt,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == last_idx);

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else if (shift_en) begin
            // After last_idx+1 shifts the received word sits LSB-aligned at [last_idx:0].
            sr_d           = sr_q >> 1;
            sr_d[last_idx] = serial_in;
            cnt_d          = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign serial_out = sr_q[0];
    assign data_nxt   = sr_d[OW-1:0];
    assign cnt        = cnt_q;

endmodule

// File: rtl/bus_master_port.sv
// Serial-bus master: arbitrates for the bus, shifts address and write data out
// LSB-first, and collects read data from the addressed slave.
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int ADDRESS_WIDTH = BUS_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = BUS_DATA_WIDTH,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req,
    input  logic                     req_wr,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     ready,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     arbiter_req,
    input  logic                     arbiter_grant,
    output logic                     bus_util,
    output logic                     rd_wrt,
    input  logic                     slave_busy,
    inout  wire                      data_bus_serial
);

    localparam int SR_W = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(SR_W);
    localparam int TW   = $clog2(TIMEOUT + 1);

    bus_state_e               state_q, state_d;
    logic                     wr_q, wr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     oe_q, oe_d;
    logic                     err_q, err_d;
    logic [TW-1:0]            to_q, to_d;
    logic                     busy_seen_q, busy_seen_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;

    logic                     su_load, su_shift, su_out, su_last;
    logic [SR_W-1:0]          su_load_data;
    logic [CW-1:0]            su_last_idx, su_cnt;
    logic [DATA_WIDTH-1:0]    su_data_nxt;

    serial_shift_unit #(.W(SR_W), .OW(DATA_WIDTH), .CW(CW)) u_shift (
        .clk       (clk),
        .rstn      (rstn),
        .load      (su_load),
        .load_data (su_load_data),
        .shift_en  (su_shift),
        .serial_in (data_bus_serial),
        .last_idx  (su_last_idx),
        .serial_out(su_out),
        .data_nxt  (su_data_nxt),
        .cnt       (su_cnt),
        .last      (su_last)
    );

    // Grant gates the enable combinationally so a lost grant frees the line at once.
    assign data_bus_serial = (oe_q && arbiter_grant) ? su_out : 1'bz;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        oe_d         = oe_q;
        err_d        = err_q;
        to_d         = to_q;
        busy_seen_d  = busy_seen_q;
        rd_data_d    = rd_data_q;
        su_load      = 1'b0;
        su_shift     = 1'b0;
        su_load_data = SR_W'(addr_q);
        su_last_idx  = (state_q == ST_ADDR) ? CW'(ADDRESS_WIDTH - 1) : CW'(DATA_WIDTH - 1);
        case (state_q)
            ST_IDLE: if (req) begin
                wr_d    = req_wr;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                state_d = ST_REQ;
            end
            ST_REQ: if (arbiter_grant) begin
                su_load = 1'b1;
                oe_d    = 1'b1;
                state_d = ST_ADDR;
            end
            ST_ADDR: if (!arbiter_grant) begin
                oe_d = 1'b0; err_d = 1'b1; state_d = ST_DONE;
            end else begin
                su_shift = 1'b1;
                if (su_last && wr_q) begin
                    su_load      = 1'b1;
                    su_load_data = SR_W'(wdata_q);
                    state_d      = ST_WDATA;
                end else if (su_last) begin
                    oe_d        = 1'b0;
                    to_d        = '0;
                    busy_seen_d = 1'b0;
                    state_d     = ST_RWAIT;
                end
            end
            ST_WDATA: if (!arbiter_grant) begin
                oe_d = 1'b0; err_d = 1'b1; state_d = ST_DONE;
            end else begin
                su_shift = 1'b1;
                if (su_last) begin
                    oe_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_RWAIT: if (!arbiter_grant) begin
                err_d = 1'b1; state_d = ST_DONE;
            end else if (busy_seen_q && !slave_busy) begin
                su_shift = 1'b1;
                state_d  = ST_RDATA;
            end else if (to_q == TW'(TIMEOUT - 1)) begin
                err_d = 1'b1; state_d = ST_DONE;
            end else begin
                to_d = to_q + 1'b1;
                if (slave_busy) busy_seen_d = 1'b1;
            end
            ST_RDATA: if (!arbiter_grant) begin
                err_d = 1'b1; state_d = ST_DONE;
            end else begin
                su_shift = 1'b1;
                if (su_last) begin
                    rd_data_d = su_data_nxt;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            oe_q        <= 1'b0;
            err_q       <= 1'b0;
            to_q        <= '0;
            busy_seen_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            oe_q        <= oe_d;
            err_q       <= err_d;
            to_q        <= to_d;
            busy_seen_q <= busy_seen_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = err_q;
    assign bus_util    = (state_q == ST_ADDR) || (state_q == ST_WDATA) ||
                         (state_q == ST_RWAIT) || (state_q == ST_RDATA);
    assign arbiter_req = (state_q == ST_REQ) || bus_util;
    assign rd_wrt      = bus_util && wr_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: writes, reads, timeout, grant loss,
// ignored requests and mid-transfer reset against a small slave model.
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        req_wr;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ready, done, error;
  logic [7:0]  rd_data;
  logic        arbiter_req;
  logic        arbiter_grant;
  logic        bus_util, rd_wrt;
  logic        slave_busy;
  logic        tb_drv_en, tb_drv_bit;
  wire         data_bus_serial;
  wire         line_z = (data_bus_serial === 1'bz);

  int n_cmp = 0;
  int n_err = 0;

  assign data_bus_serial = tb_drv_en ? tb_drv_bit : 1'bz;

  always #5 clk = ~clk;

  bus_master_port #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .TIMEOUT(20)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req            (req),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ready          (ready),
    .done           (done),
    .error          (error),
    .rd_data        (rd_data),
    .arbiter_req    (arbiter_req),
    .arbiter_grant  (arbiter_grant),
    .bus_util       (bus_util),
    .rd_wrt         (rd_wrt),
    .slave_busy     (slave_busy),
    .data_bus_serial(data_bus_serial)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_write(input logic [14:0] a, input logic [7:0] d, input int pulse_at);
    logic [22:0] cap;
    logic        phase_ok;
    req = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    step();
    req = 1'b0;
    chk("wr_arb_req", arbiter_req, 1);
    chk("wr_busy_ready", ready, 0);
    arbiter_grant = 1'b1;
    step();
    phase_ok = 1'b1;
    for (int i = 0; i < 23; i++) begin
      cap[i] = data_bus_serial;
      if (bus_util !== 1'b1 || rd_wrt !== 1'b1 || done !== 1'b0) phase_ok = 1'b0;
      if (i == pulse_at) begin
        req = 1'b1; req_wr = 1'b0; req_addr = 15'h7000;
      end
      step();
      req = 1'b0;
    end
    chk("wr_addr_bits", {17'b0, cap[14:0]}, {17'b0, a});
    chk("wr_data_bits", {24'b0, cap[22:15]}, {24'b0, d});
    chk("wr_phase_outputs", phase_ok, 1);
    chk("wr_done_g24", done, 1);
    chk("wr_error", error, 0);
    chk("wr_done_util", bus_util, 0);
    chk("wr_done_line_z", line_z, 1);
    arbiter_grant = 1'b0;
    step();
    chk("wr_ready_after", ready, 1);
    chk("wr_done_cleared", done, 0);
  endtask

  task automatic start_read(input logic [14:0] a);
    logic [14:0] cap;
    req = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = 8'h00;
    step();
    req = 1'b0;
    chk("rd_arb_req", arbiter_req, 1);
    arbiter_grant = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      cap[i] = data_bus_serial;
      step();
    end
    chk("rd_addr_bits", {17'b0, cap}, {17'b0, a});
    chk("rd_rwait_line_z", line_z, 1);
    chk("rd_rwait_util", bus_util, 1);
    chk("rd_rwait_dir", rd_wrt, 0);
  endtask

  initial begin
    logic [7:0] rd_word;
    rstn = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    arbiter_grant = 1'b0; slave_busy = 1'b0; tb_drv_en = 1'b0; tb_drv_bit = 1'b0;
    step(); step();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_arb_req", arbiter_req, 0);
    chk("rst_bus_util", bus_util, 0);
    chk("rst_rd_wrt", rd_wrt, 0);
    chk("rst_line_z", line_z, 1);
    rstn = 1'b1;
    step();

    // Write 0xA5 to 0x1234 with immediate grant.
    run_write(15'h1234, 8'hA5, -1);

    // Read 0x0010: busy for three cycles, then the slave returns 0x3C.
    start_read(15'h0010);
    rd_word = 8'h3C;
    slave_busy = 1'b1;
    step(); step(); step();
    slave_busy = 1'b0;
    tb_drv_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tb_drv_bit = rd_word[i];
      if (i == 7) chk("rd_done_not_early", done, 0);
      step();
    end
    tb_drv_en = 1'b0;
    chk("rd_done", done, 1);
    chk("rd_error", error, 0);
    chk("rd_data_3c", rd_data, 8'h3C);
    arbiter_grant = 1'b0;
    step();
    chk("rd_ready_after", ready, 1);

    // Read where busy never releases: aborts after 20 RWAIT cycles.
    start_read(15'h7FFF);
    slave_busy = 1'b1;
    for (int i = 0; i < 19; i++) step();
    chk("to_not_yet", done, 0);
    chk("to_still_util", bus_util, 1);
    step();
    chk("to_done", done, 1);
    chk("to_error", error, 1);
    chk("to_rd_data_kept", rd_data, 8'h3C);
    slave_busy = 1'b0;
    arbiter_grant = 1'b0;
    step();
    chk("to_ready_after", ready, 1);
    chk("to_error_cleared", error, 0);

    // Grant dropped in the fifth address cycle.
    req = 1'b1; req_wr = 1'b1; req_addr = 15'h5555; req_wdata = 8'h11;
    step();
    req = 1'b0;
    arbiter_grant = 1'b1;
    step();
    step(); step(); step(); step();
    chk("gl_addr_bit4", data_bus_serial, 1);
    arbiter_grant = 1'b0;
    #1;
    chk("gl_line_z_same_cycle", line_z, 1);
    step();
    chk("gl_done", done, 1);
    chk("gl_error", error, 1);
    chk("gl_rd_data_kept", rd_data, 8'h3C);
    step();
    chk("gl_ready_after", ready, 1);

    // Request pulsed mid-transaction is dropped.
    run_write(15'h0ABC, 8'h5A, 2);
    step(); step();
    chk("ign_no_second_req", arbiter_req, 0);
    chk("ign_still_ready", ready, 1);

    // Reset asserted in the middle of the write data phase.
    req = 1'b1; req_wr = 1'b1; req_addr = 15'h0F0F; req_wdata = 8'h81;
    step();
    req = 1'b0;
    arbiter_grant = 1'b1;
    step();
    for (int i = 0; i < 18; i++) step();
    chk("mid_wdata_bit3", data_bus_serial, 0);
    rstn = 1'b0;
    #1;
    chk("mr_line_z", line_z, 1);
    chk("mr_ready", ready, 1);
    chk("mr_done", done, 0);
    chk("mr_error", error, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_arb_req", arbiter_req, 0);
    chk("mr_bus_util", bus_util, 0);
    chk("mr_rd_wrt", rd_wrt, 0);
    arbiter_grant = 1'b0;
    step();
    rstn = 1'b1;
    step();
    run_write(15'h0001, 8'h02, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
